// File: rtl/compare_monitor.sv
// Lockstep spec-vs-impl checker: warm-up, then RUNLEN valid samples compared per channel.
// Results register on the sampling edge; no backpressure, samples with valid=0 are skipped.
module compare_monitor #(
   parameter int CHANNELS = 6,
   parameter int WIDTH    = 1,
   parameter int WARMUP   = 30,
   parameter int RUNLEN   = 10000,
   parameter int CNTW     = 16
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic                                           start,
   input  logic                                           valid,
   input  logic [CHANNELS*WIDTH-1:0]                      spec,
   input  logic [CHANNELS*WIDTH-1:0]                      impl,
   output logic                                           busy,
   output logic                                           checking,
   output logic                                           done,
   output logic                                           fail,
   output logic [CHANNELS-1:0]                            chan_fail,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] first_chan,
   output logic [CNTW-1:0]                                first_cycle,
   output logic [CNTW-1:0]                                err_count,
   output logic [CNTW-1:0]                                sample_count
);

   localparam int FCW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int WW    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam int WLAST = (WARMUP > 0) ? WARMUP - 1 : 0;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WARMUP = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [1:0]      S_START     = (WARMUP == 0) ? S_CHECK : S_WARMUP;
   localparam logic [CNTW-1:0] LAST_SAMPLE = CNTW'(RUNLEN - 1);
   localparam logic [WW-1:0]   WARM_LAST   = WW'(WLAST);

   logic [1:0]          state;
   logic [WW-1:0]       warm_cnt;
   logic [CHANNELS-1:0] mism;
   logic [FCW-1:0]      low_idx;

   always_comb begin
      mism = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         mism[c] = (spec[c*WIDTH +: WIDTH] != impl[c*WIDTH +: WIDTH]);
      end
   end

   // Scan high to low so the lowest mismatching channel wins.
   always_comb begin
      low_idx = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (mism[c]) begin
            low_idx = FCW'(c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         warm_cnt     <= '0;
         fail         <= 1'b0;
         chan_fail    <= '0;
         first_chan   <= '0;
         first_cycle  <= '0;
         err_count    <= '0;
         sample_count <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state        <= S_START;
                  warm_cnt     <= '0;
                  fail         <= 1'b0;
                  chan_fail    <= '0;
                  first_chan   <= '0;
                  first_cycle  <= '0;
                  err_count    <= '0;
                  sample_count <= '0;
               end
            end
            S_WARMUP: begin
               if (warm_cnt == WARM_LAST) begin
                  state <= S_CHECK;
               end else begin
                  warm_cnt <= warm_cnt + WW'(1);
               end
            end
            S_CHECK: begin
               if (valid) begin
                  sample_count <= sample_count + CNTW'(1);
                  if (|mism) begin
                     if (err_count != {CNTW{1'b1}}) begin
                        err_count <= err_count + CNTW'(1);
                     end
                     chan_fail <= chan_fail | mism;
                     if (!fail) begin
                        fail        <= 1'b1;
                        first_chan  <= low_idx;
                        first_cycle <= sample_count;
                     end
                  end
                  if (sample_count == LAST_SAMPLE) begin
                     state <= S_DONE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy     = (state == S_WARMUP) || (state == S_CHECK);
   assign checking = (state == S_CHECK);
   assign done     = (state == S_DONE);

endmodule

// File: tb/tb_compare_monitor.sv
// Directed bench for compare_monitor: main instance (WARMUP=3, RUNLEN=8, CNTW=8)
// and a saturation instance (WARMUP=0, RUNLEN=7, CNTW=3).
module tb_compare_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       sstart;
   logic       valid;
   logic [5:0] spec;
   logic [5:0] impl;

   logic       busy, checking, done, fail;
   logic [5:0] chan_fail;
   logic [2:0] first_chan;
   logic [7:0] first_cycle, err_count, sample_count;

   logic       s_busy, s_checking, s_done, s_fail;
   logic [5:0] s_chan_fail;
   logic [2:0] s_first_chan;
   logic [2:0] s_first_cycle, s_err_count, s_sample_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   compare_monitor #(
      .CHANNELS(6), .WIDTH(1), .WARMUP(3), .RUNLEN(8), .CNTW(8)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start), .valid(valid),
      .spec(spec), .impl(impl),
      .busy(busy), .checking(checking), .done(done), .fail(fail),
      .chan_fail(chan_fail), .first_chan(first_chan), .first_cycle(first_cycle),
      .err_count(err_count), .sample_count(sample_count)
   );

   compare_monitor #(
      .CHANNELS(6), .WIDTH(1), .WARMUP(0), .RUNLEN(7), .CNTW(3)
   ) u_sat (
      .clk(clk), .reset(reset), .start(sstart), .valid(valid),
      .spec(spec), .impl(impl),
      .busy(s_busy), .checking(s_checking), .done(s_done), .fail(s_fail),
      .chan_fail(s_chan_fail), .first_chan(s_first_chan), .first_cycle(s_first_cycle),
      .err_count(s_err_count), .sample_count(s_sample_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; sstart = 1'b0; valid = 1'b0;
      spec = 6'h00; impl = 6'h00;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_check",  32'(checking), 32'd0);
      chk("rst_done",   32'(done), 32'd0);
      chk("rst_fail",   32'(fail), 32'd0);
      chk("rst_chfail", 32'(chan_fail), 32'd0);
      chk("rst_fchan",  32'(first_chan), 32'd0);
      chk("rst_fcyc",   32'(first_cycle), 32'd0);
      chk("rst_err",    32'(err_count), 32'd0);
      chk("rst_samp",   32'(sample_count), 32'd0);
      chk("rst_s_busy", 32'(s_busy), 32'd0);

      // Clean run; all channels mismatch during warm-up and must be ignored.
      start = 1'b1; valid = 1'b1; spec = 6'h3F; impl = 6'h00;
      tick();
      start = 1'b0;
      chk("clean_busy0",  32'(busy), 32'd1);
      chk("clean_chk0",   32'(checking), 32'd0);
      tick(); tick();
      chk("clean_chk2",   32'(checking), 32'd0);
      spec = 6'h15; impl = 6'h15;
      tick();
      chk("clean_chk3",   32'(checking), 32'd1);
      chk("clean_samp3",  32'(sample_count), 32'd0);
      for (int i = 0; i < 7; i++) tick();
      chk("clean_done10", 32'(done), 32'd0);
      chk("clean_samp10", 32'(sample_count), 32'd7);
      tick();
      chk("clean_done",   32'(done), 32'd1);
      chk("clean_busy",   32'(busy), 32'd0);
      chk("clean_chkoff", 32'(checking), 32'd0);
      chk("clean_samp",   32'(sample_count), 32'd8);
      chk("clean_fail",   32'(fail), 32'd0);
      chk("clean_err",    32'(err_count), 32'd0);
      chk("clean_chfail", 32'(chan_fail), 32'd0);

      // Restart from DONE, first-fail capture, start coincident with final sample.
      start = 1'b1; spec = 6'h00; impl = 6'h00;
      tick();
      start = 1'b0;
      chk("rs_done",  32'(done), 32'd0);
      chk("rs_busy",  32'(busy), 32'd1);
      chk("rs_samp",  32'(sample_count), 32'd0);
      tick(); tick(); tick();
      for (int i = 0; i < 8; i++) begin
         impl  = (i == 3) ? 6'b010100 : (i == 5) ? 6'b000001 : 6'b000000;
         start = (i == 7);
         tick();
         if (i == 3) begin
            chk("ff_fail3",  32'(fail), 32'd1);
            chk("ff_fchan3", 32'(first_chan), 32'd2);
            chk("ff_fcyc3",  32'(first_cycle), 32'd3);
         end
      end
      start = 1'b0; impl = 6'h00;
      chk("ff_done",   32'(done), 32'd1);
      chk("ff_fail",   32'(fail), 32'd1);
      chk("ff_fchan",  32'(first_chan), 32'd2);
      chk("ff_fcyc",   32'(first_cycle), 32'd3);
      chk("ff_err",    32'(err_count), 32'd2);
      chk("ff_chfail", 32'(chan_fail), 32'b010101);
      tick();
      chk("ff_hold_done", 32'(done), 32'd1);
      chk("ff_hold_err",  32'(err_count), 32'd2);

      // valid gaps: mismatching data on valid=0 cycles must be ignored.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      for (int j = 0; j < 15; j++) begin
         valid = (j % 2 == 0);
         spec  = valid ? 6'h2A : 6'h3F;
         impl  = valid ? 6'h2A : 6'h00;
         tick();
         if (j == 13) begin
            chk("gap_done13", 32'(done), 32'd0);
            chk("gap_samp13", 32'(sample_count), 32'd7);
         end
      end
      chk("gap_done", 32'(done), 32'd1);
      chk("gap_samp", 32'(sample_count), 32'd8);
      chk("gap_fail", 32'(fail), 32'd0);
      chk("gap_err",  32'(err_count), 32'd0);

      // Reset mid-run after a failure.
      valid = 1'b1; spec = 6'h00; impl = 6'h00; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 4; i++) begin
         spec = (i == 1) ? 6'h20 : 6'h00;
         tick();
      end
      chk("mr_fail",  32'(fail), 32'd1);
      chk("mr_fchan", 32'(first_chan), 32'd5);
      chk("mr_fcyc",  32'(first_cycle), 32'd1);
      chk("mr_samp",  32'(sample_count), 32'd4);
      reset = 1'b1; start = 1'b1; spec = 6'h3F;
      tick();
      reset = 1'b0; start = 1'b0; spec = 6'h00;
      chk("mr_busy",   32'(busy), 32'd0);
      chk("mr_done",   32'(done), 32'd0);
      chk("mr_fail0",  32'(fail), 32'd0);
      chk("mr_chf0",   32'(chan_fail), 32'd0);
      chk("mr_fcyc0",  32'(first_cycle), 32'd0);
      chk("mr_err0",   32'(err_count), 32'd0);
      chk("mr_samp0",  32'(sample_count), 32'd0);
      tick();
      chk("mr_idle",   32'(busy), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 11; i++) tick();
      chk("mr2_done", 32'(done), 32'd1);
      chk("mr2_fail", 32'(fail), 32'd0);
      chk("mr2_err",  32'(err_count), 32'd0);
      chk("mr2_samp", 32'(sample_count), 32'd8);

      // Saturation instance: WARMUP=0, every sample mismatching on all channels.
      sstart = 1'b1; spec = 6'h3F; impl = 6'h00;
      tick();
      sstart = 1'b0;
      chk("sat_chk0", 32'(s_checking), 32'd1);
      chk("sat_err0", 32'(s_err_count), 32'd0);
      for (int i = 0; i < 6; i++) tick();
      chk("sat_err6",  32'(s_err_count), 32'd6);
      chk("sat_done6", 32'(s_done), 32'd0);
      tick();
      chk("sat_done",   32'(s_done), 32'd1);
      chk("sat_err",    32'(s_err_count), 32'd7);
      chk("sat_samp",   32'(s_sample_count), 32'd7);
      chk("sat_fcyc",   32'(s_first_cycle), 32'd0);
      chk("sat_fchan",  32'(s_first_chan), 32'd0);
      chk("sat_chfail", 32'(s_chan_fail), 32'h3F);
      chk("sat_main_hold", 32'(err_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
